// File: rtl/urisc_dmem_resp_if.sv
// urisc_dmem_resp_if: CPU request bus and output-port stream of the URISC data memory
interface urisc_dmem_resp_if #(
  parameter int AW = 9,
  parameter int WIDTH = 16
);
  logic CS;
  logic Read;
  logic Write;
  logic [AW-1:0] Addr;
  logic [WIDTH-1:0] Data_in;
  logic [WIDTH-1:0] Data_out;
  logic Busy;
  logic [WIDTH-1:0] io_data;
  logic io_valid;
  logic io_ready;
  logic io_overflow;
  modport master (
    output CS, Read, Write, Addr, Data_in, io_ready,
    input Data_out, Busy, io_data, io_valid, io_overflow
  );
  modport slave (
    input CS, Read, Write, Addr, Data_in, io_ready,
    output Data_out, Busy, io_data, io_valid, io_overflow
  );
endinterface

// File: rtl/urisc_dmem_resp.sv
// urisc_dmem_resp: URISC data memory with memory-mapped output FIFO; DMEM_INIT_CLEAR_EN adds a zeroing sweep after reset
module urisc_dmem_resp #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  parameter logic [$clog2(DEPTH)-1:0] IO_ADDR = 9'h1FF,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  urisc_dmem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic ovf_q, ovf_d;
  logic run, req, is_io, full, push, pop, we;
  logic [AW-1:0] wa;
  logic [WIDTH-1:0] wd;
`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] swp_q, swp_d;
  always_ff @(posedge clk) begin
    state_q <= !reset ? INIT : state_d;
    swp_q <= !reset ? '0 : swp_d;
  end
  always_comb begin
    state_d = (state_q == INIT && swp_q == AW'(DEPTH - 1)) ? RUN : state_q;
    swp_d = (state_q == INIT) ? swp_q + 1'b1 : swp_q;
  end
  assign run = state_q == RUN;
  assign we = !run || (req && bus.Write && !is_io);
  assign wa = run ? bus.Addr : swp_q;
  assign wd = run ? bus.Data_in : '0;
`else
  assign run = 1'b1;
  assign we = req && bus.Write && !is_io;
  assign wa = bus.Addr;
  assign wd = bus.Data_in;
`endif
  assign req = run && bus.CS;
  assign is_io = bus.Addr == IO_ADDR;
  assign full = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign pop = cnt_q != '0 && bus.io_ready;
  // a full FIFO still takes a push when the head leaves on the same edge
  assign push = req && bus.Write && is_io && (!full || pop);
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d = ovf_q || (req && bus.Write && is_io && full && !pop);
    dout_d = (req && bus.Read && !bus.Write) ? (is_io ? WIDTH'(cnt_q) : mem_q[bus.Addr]) : dout_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
    if (push) fifo_q[wr_ptr_q] <= bus.Data_in;
  end
  assign bus.Data_out = dout_q;
  assign bus.Busy = !run;
  assign bus.io_data = fifo_q[rd_ptr_q];
  assign bus.io_valid = cnt_q != '0;
  assign bus.io_overflow = ovf_q;
endmodule

// File: tb/tb_urisc_dmem_resp.sv
// tb_urisc_dmem_resp: directed vector bench for urisc_dmem_resp
module tb_urisc_dmem_resp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  urisc_dmem_resp_if bus ();
  urisc_dmem_resp dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef DMEM_INIT_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
  localparam int SWEEP = 512;
`else
  localparam logic BUSY_RST = 1'b0;
  localparam int SWEEP = 0;
`endif
  typedef struct {
    logic [3:0] ctl;
    logic [8:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0] vo;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic [3:0] ctl, logic [8:0] a, logic [15:0] d, logic [15:0] dout, logic [1:0] vo, logic [15:0] data);
    vec_t v;
    v.ctl = ctl;
    v.addr = a;
    v.din = d;
    v.dout = dout;
    v.vo = vo;
    v.data = data;
    return v;
  endfunction
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chkb(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [3:0] ctl, logic [8:0] a, logic [15:0] d);
    {bus.CS, bus.Read, bus.Write, bus.io_ready} = ctl;
    bus.Addr = a;
    bus.Data_in = d;
  endtask
  task automatic do_reset();
    drive(4'b0000, 9'h000, 16'h0000);
    reset = 1'b0;
    step();
    chk("rst_dout", bus.Data_out, 16'h0000);
    chkb("rst_valid", bus.io_valid, 1'b0);
    chkb("rst_ovf", bus.io_overflow, 1'b0);
    chkb("rst_busy", bus.Busy, BUSY_RST);
    reset = 1'b1;
  endtask
  task automatic sweep();
    int n = 0;
    while (bus.Busy && n < 600) begin
      step();
      n++;
    end
    chk("sweep_len", 16'(n), 16'(SWEEP));
  endtask
  initial begin
    // ctl = {CS, Read, Write, io_ready}; vo = {io_valid, io_overflow}
    tbl.push_back(mk(4'b1010, 9'h010, 16'h1234, 16'h0000, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1100, 9'h010, 16'h0000, 16'h1234, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b0100, 9'h020, 16'h0000, 16'h1234, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1000, 9'h020, 16'h0000, 16'h1234, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1110, 9'h020, 16'hBEEF, 16'h1234, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1100, 9'h020, 16'h0000, 16'hBEEF, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1010, 9'h021, 16'h5A5A, 16'hBEEF, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1100, 9'h021, 16'h0000, 16'h5A5A, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1100, 9'h010, 16'h0000, 16'h1234, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1100, 9'h1FF, 16'h0000, 16'h0000, 2'b00, 16'h0000));
    tbl.push_back(mk(4'b1010, 9'h1FF, 16'h0001, 16'h0000, 2'b10, 16'h0001));
    tbl.push_back(mk(4'b1010, 9'h1FF, 16'h0002, 16'h0000, 2'b10, 16'h0001));
    tbl.push_back(mk(4'b1010, 9'h1FF, 16'h0003, 16'h0000, 2'b10, 16'h0001));
    tbl.push_back(mk(4'b1010, 9'h1FF, 16'h0004, 16'h0000, 2'b10, 16'h0001));
    tbl.push_back(mk(4'b1010, 9'h1FF, 16'h0005, 16'h0000, 2'b11, 16'h0001));
    tbl.push_back(mk(4'b1100, 9'h1FF, 16'h0000, 16'h0004, 2'b11, 16'h0001));
    tbl.push_back(mk(4'b0001, 9'h000, 16'h0000, 16'h0004, 2'b11, 16'h0002));
    tbl.push_back(mk(4'b0001, 9'h000, 16'h0000, 16'h0004, 2'b11, 16'h0003));
    tbl.push_back(mk(4'b0001, 9'h000, 16'h0000, 16'h0004, 2'b11, 16'h0004));
    tbl.push_back(mk(4'b0001, 9'h000, 16'h0000, 16'h0004, 2'b01, 16'h0000));
    tbl.push_back(mk(4'b1101, 9'h1FF, 16'h0000, 16'h0000, 2'b01, 16'h0000));
    tbl.push_back(mk(4'b1011, 9'h1FF, 16'h0007, 16'h0000, 2'b11, 16'h0007));
    tbl.push_back(mk(4'b0000, 9'h000, 16'h0000, 16'h0000, 2'b11, 16'h0007));
    tbl.push_back(mk(4'b1100, 9'h010, 16'h0000, 16'h1234, 2'b11, 16'h0007));
    do_reset();
`ifdef DMEM_INIT_CLEAR_EN
    drive(4'b1010, 9'h0A5, 16'hFFFF);
`endif
    sweep();
`ifdef DMEM_INIT_CLEAR_EN
    drive(4'b1100, 9'h000, 16'h0000);
    step();
    chk("clr_000", bus.Data_out, 16'h0000);
    drive(4'b1100, 9'h0A5, 16'h0000);
    step();
    chk("clr_0a5", bus.Data_out, 16'h0000);
    drive(4'b1100, 9'h1FE, 16'h0000);
    step();
    chk("clr_1fe", bus.Data_out, 16'h0000);
    chkb("clr_valid", bus.io_valid, 1'b0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ctl, tbl[i].addr, tbl[i].din);
      step();
      chk($sformatf("vec%0d_dout", i), bus.Data_out, tbl[i].dout);
      chkb($sformatf("vec%0d_valid", i), bus.io_valid, tbl[i].vo[1]);
      chkb($sformatf("vec%0d_ovf", i), bus.io_overflow, tbl[i].vo[0]);
      chkb($sformatf("vec%0d_busy", i), bus.Busy, 1'b0);
      if (tbl[i].vo[1]) chk($sformatf("vec%0d_data", i), bus.io_data, tbl[i].data);
    end
    do_reset();
    sweep();
    drive(4'b1010, 9'h1FF, 16'h0006);
    step();
    drive(4'b1010, 9'h1FF, 16'h0007);
    step();
    drive(4'b1010, 9'h1FF, 16'h0008);
    step();
    drive(4'b1010, 9'h1FF, 16'h000A);
    step();
    chk("full_head", bus.io_data, 16'h0006);
    chkb("full_ovf", bus.io_overflow, 1'b0);
    drive(4'b1011, 9'h1FF, 16'h0009);
    step();
    chkb("pp_ovf", bus.io_overflow, 1'b0);
    chk("pp_head", bus.io_data, 16'h0007);
    drive(4'b1100, 9'h1FF, 16'h0000);
    step();
    chk("pp_count", bus.Data_out, 16'h0004);
    drive(4'b0001, 9'h000, 16'h0000);
    step();
    chk("drain_0", bus.io_data, 16'h0008);
    step();
    chk("drain_1", bus.io_data, 16'h000A);
    step();
    chk("drain_2", bus.io_data, 16'h0009);
    chkb("drain_2v", bus.io_valid, 1'b1);
    step();
    chkb("drain_empty", bus.io_valid, 1'b0);
    chkb("drain_ovf", bus.io_overflow, 1'b0);
`ifdef DMEM_INIT_CLEAR_EN
    do_reset();
    repeat (100) step();
    chkb("mid_busy", bus.Busy, 1'b1);
    do_reset();
    sweep();
    chkb("mid_valid", bus.io_valid, 1'b0);
    chkb("mid_ovf", bus.io_overflow, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/urisc_dmem_resp.md
# urisc_dmem_resp

Responder end of the URISC data-memory port: accepts CPU chip-select/read/write requests on a 9-bit address and 16-bit data bus, serves them from a 512x16 internal array with one-cycle registered read latency, and diverts writes to one memory-mapped address into a 4-entry output FIFO drained by an external valid/ready consumer. It sits in place of the plain data memory beside the URISC core, connected to Data_CS, Read, Write, MAR and the two data buses.

## Interface
- DEPTH, 512, number of 16-bit words in the array
- WIDTH, 16, data word width
- IO_ADDR, 9'h1FF, memory-mapped output-port address
- FIFO_DEPTH, 4, output FIFO entries (power of two)
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low
- CS  input  1  request strobe from core (Data_CS)
- Read  input  1  read request, qualified by CS
- Write  input  1  write request, qualified by CS
- Addr  input  9  word address (MAR)
- Data_in  input  16  write data from core
- Data_out  output  16  registered read data to core
- Busy  output  1  array not yet usable (init sweep in progress)
- io_data  output  16  FIFO head word
- io_valid  output  1  FIFO non-empty
- io_ready  input  1  consumer accepts head word
- io_overflow  output  1  sticky: a push was dropped on full

## Operation
- States: INIT (only with clear sweep compiled in), RUN. Reset (reset=0 at a clock edge) enters INIT if compiled in, else RUN.
- INIT: 9-bit sweep counter writes 0 to array[cnt], cnt 0..DEPTH-1, one word/cycle; at cnt=DEPTH-1 go to RUN. Busy=1 throughout INIT. All CPU requests ignored; FIFO held empty.
- RUN, CS=1 & Write=1: Addr==IO_ADDR -> push Data_in into FIFO; else array[Addr] <= Data_in. Write has priority over Read when both set; Data_out unchanged.
- RUN, CS=1 & Read=1 & Write=0: Addr==IO_ADDR -> Data_out <= {13'b0, count[2:0]} (count 0..4); else Data_out <= array[Addr]. Read of an address written the previous cycle returns the new value.
- CS=0, or Read=Write=0: no action; Data_out holds last value.
- FIFO: pop when io_valid & io_ready. Push when not full -> accepted. Push when full with simultaneous pop -> accepted, count stays FIFO_DEPTH. Push when full without pop -> dropped, io_overflow <= 1 (cleared only by reset). Pop when empty -> no effect. io_data = head entry, don't-care when io_valid=0. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation (including mid-sweep): FIFO emptied, sweep counter restarts at 0, array contents beyond sweep not guaranteed.

## Timing
- Reset values: Data_out=16'h0000, io_valid=0, io_overflow=0, Busy=1 (sweep compiled in) or 0 (not), FIFO count=0.
- Read latency 1: request sampled at edge N, Data_out valid after edge N, held until next read.
- Write/push effective at the sampling edge; io_valid rises after the same edge as an accepted push into an empty FIFO.
- Pop effective at edge where io_valid & io_ready; io_data updates after that edge.
- Sweep: Busy falls after edge DEPTH following reset release (512 cycles at default).
- No combinational path from inputs to any output.

## Configuration
- DMEM_INIT_CLEAR_EN defined: INIT sweep present, array guaranteed zero after Busy falls, Busy=1 out of reset.
- Not defined: no INIT state, no sweep counter, Busy tied 0, array contents after reset unspecified, RUN entered immediately.

## Test plan
- Reset with DMEM_INIT_CLEAR_EN, hold 1 cycle, release -> Busy=1 for 512 cycles then 0; reads of 0x000, 0x0A5, 0x1FE return 0x0000.
- Write 0x1234 to 0x010, read 0x010 next cycle -> Data_out=0x1234 one cycle after read strobe; CS=0 cycles afterwards keep 0x1234.
- CS=1, Read=1, Write=1, Addr=0x020, Data_in=0xBEEF -> array[0x020]=0xBEEF, Data_out unchanged; following read returns 0xBEEF.
- io_ready=0, five writes 0x0001..0x0005 to 0x1FF -> read 0x1FF returns 0x0004, io_overflow=1; then io_ready=1 -> io_data sequence 0x0001..0x0004, io_valid falls after 4th pop.
- FIFO full, simultaneous push 0x0009 and pop -> no overflow, count stays 4, 0x0009 drained last.
- Reset asserted at sweep cycle 100 -> Busy stays 1, sweep restarts, Busy falls 512 cycles after release; FIFO empty, io_overflow=0.
